// File: rtl/arp_pkg.sv
// Shared types for the ARP request scheduler: entry layout and FSM encoding.
package arp_pkg;

  localparam int ARP_NETPORT_W = 24;
  localparam int ARP_IP_W      = 32;
  localparam int ARP_ENTRY_W   = ARP_NETPORT_W + ARP_IP_W;

  typedef struct packed {
    logic [ARP_NETPORT_W-1:0] netport;
    logic [ARP_IP_W-1:0]      ip;
  } arp_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arp_state_t;

endpackage

// File: rtl/arp_req_fifo.sv
// Small synchronous FIFO with full/empty flags; head entry is visible combinationally.
module arp_req_fifo #(
  parameter int AW = 2,
  parameter int W  = 56
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/arp_req_sched.sv
// Merges forwarding-path misses and aging re-queries into one paced ARP request stream.
// Optional repeated-miss suppression is enabled by defining ARP_REQ_DEDUP_EN.
module arp_req_sched
  import arp_pkg::*;
#(
  parameter int          MISS_AW    = 2,
  parameter logic [15:0] GAP_CYCLES = 16'd1250,
  parameter logic [2:0]  STARVE_MAX = 3'd4,
  parameter logic [23:0] DEDUP_HOLD = 24'd125000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic [ARP_NETPORT_W-1:0] miss_netport,
  input  logic [ARP_IP_W-1:0]      miss_ip,
  input  logic                     age_req_en,
  input  logic [ARP_NETPORT_W-1:0] age_netport,
  input  logic [ARP_IP_W-1:0]      age_ip,
  output logic                     arp_tx_valid,
  input  logic                     arp_tx_ready,
  output logic [ARP_NETPORT_W-1:0] arp_tx_netport,
  output logic [ARP_IP_W-1:0]      arp_tx_ip,
  output logic                     arp_tx_src,
  output logic [15:0]              age_drop_cnt
);

  arp_state_t  state_q, state_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]  starve_q, starve_d;
  logic        age_vld_q, age_vld_d;
  arp_entry_t  age_ent_q, age_ent_d;
  logic [15:0] drop_q, drop_d;
  logic        tx_valid_q, tx_valid_d;
  arp_entry_t  tx_ent_q, tx_ent_d;
  logic        tx_src_q, tx_src_d;

  arp_entry_t  miss_entry, miss_head;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic        pick_age, take_age, take_miss, suppress, emit_miss;

  assign miss_entry = '{netport: miss_netport, ip: miss_ip};

  arp_req_fifo #(
    .AW (MISS_AW),
    .W  (ARP_ENTRY_W)
  ) u_miss_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (miss_valid),
    .wr_data (miss_entry),
    .pop     (fifo_pop),
    .rd_data (miss_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Miss wins unless the age entry has waited through STARVE_MAX miss grants.
  assign pick_age  = age_vld_q && (fifo_empty || starve_q == STARVE_MAX);
  assign take_age  = (state_q == IDLE) && pick_age;
  assign take_miss = (state_q == IDLE) && !pick_age && !fifo_empty;
  assign emit_miss = take_miss && !suppress;
  assign fifo_pop  = take_miss;

`ifdef ARP_REQ_DEDUP_EN
  logic [ARP_IP_W-1:0] last_ip_q, last_ip_d;
  logic [23:0]         hold_q, hold_d;

  // A suppressed miss is popped but never reloads the hold window.
  assign suppress = take_miss && (miss_head.ip == last_ip_q) && (hold_q != 24'd0);

  always_comb begin
    last_ip_d = last_ip_q;
    hold_d    = (hold_q != 24'd0) ? hold_q - 24'd1 : 24'd0;
    if (emit_miss) begin
      last_ip_d = miss_head.ip;
      hold_d    = DEDUP_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ip_q <= '0;
      hold_q    <= '0;
    end else begin
      last_ip_q <= last_ip_d;
      hold_q    <= hold_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      starve_q   <= '0;
      age_vld_q  <= 1'b0;
      age_ent_q  <= '0;
      drop_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_ent_q   <= '0;
      tx_src_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      starve_q   <= starve_d;
      age_vld_q  <= age_vld_d;
      age_ent_q  <= age_ent_d;
      drop_q     <= drop_d;
      tx_valid_q <= tx_valid_d;
      tx_ent_q   <= tx_ent_d;
      tx_src_q   <= tx_src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_age || emit_miss) state_d = ISSUE;
      ISSUE:   if (arp_tx_ready) state_d = (GAP_CYCLES == 16'd0) ? IDLE : GAP;
      GAP:     if (gap_cnt_q == GAP_CYCLES - 16'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_ent_d   = tx_ent_q;
    tx_src_d   = tx_src_q;
    starve_d   = starve_q;
    gap_cnt_d  = (state_q == GAP) ? gap_cnt_q + 16'd1 : 16'd0;
    if (take_age) begin
      tx_valid_d = 1'b1;
      tx_ent_d   = age_ent_q;
      tx_src_d   = 1'b1;
      starve_d   = 3'd0;
    end else if (emit_miss) begin
      tx_valid_d = 1'b1;
      tx_ent_d   = miss_head;
      tx_src_d   = 1'b0;
      if (age_vld_q) starve_d = starve_q + 3'd1;
    end
    if (state_q == ISSUE && arp_tx_ready) tx_valid_d = 1'b0;

    // A pulse arriving as the held entry is granted refills the slot instead of dropping.
    age_vld_d = age_vld_q && !take_age;
    age_ent_d = age_ent_q;
    drop_d    = drop_q;
    if (age_req_en) begin
      if (!age_vld_d) begin
        age_vld_d = 1'b1;
        age_ent_d = '{netport: age_netport, ip: age_ip};
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
  end

  assign miss_ready     = !fifo_full;
  assign arp_tx_valid   = tx_valid_q;
  assign arp_tx_netport = tx_ent_q.netport;
  assign arp_tx_ip      = tx_ent_q.ip;
  assign arp_tx_src     = tx_src_q;
  assign age_drop_cnt   = drop_q;

endmodule

// File: tb/tb_arp_req_sched.sv
// Self-checking bench for arp_req_sched: directed vector table, corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_arp_req_sched;

  localparam logic [15:0] GAP    = 16'd4;
  localparam logic [2:0]  STARVE = 3'd4;
  localparam logic [23:0] HOLD   = 24'd1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid, miss_ready;
  logic [23:0] miss_netport;
  logic [31:0] miss_ip;
  logic        age_req_en;
  logic [23:0] age_netport;
  logic [31:0] age_ip;
  logic        arp_tx_valid, arp_tx_ready;
  logic [23:0] arp_tx_netport;
  logic [31:0] arp_tx_ip;
  logic        arp_tx_src;
  logic [15:0] age_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  arp_req_sched #(
    .MISS_AW    (2),
    .GAP_CYCLES (GAP),
    .STARVE_MAX (STARVE),
    .DEDUP_HOLD (HOLD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .miss_valid     (miss_valid),
    .miss_ready     (miss_ready),
    .miss_netport   (miss_netport),
    .miss_ip        (miss_ip),
    .age_req_en     (age_req_en),
    .age_netport    (age_netport),
    .age_ip         (age_ip),
    .arp_tx_valid   (arp_tx_valid),
    .arp_tx_ready   (arp_tx_ready),
    .arp_tx_netport (arp_tx_netport),
    .arp_tx_ip      (arp_tx_ip),
    .arp_tx_src     (arp_tx_src),
    .age_drop_cnt   (age_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] np;
    logic [31:0] ip;
  } ent_t;

  typedef struct {
    bit          mv;
    logic [31:0] mip;
    bit          age;
    logic [31:0] aip;
    bit          rdy;
    bit          ev;
    bit          esrc;
    logic [31:0] eip;
    logic [15:0] edrop;
  } vec_t;

  // Reference model: pending misses as a queue, pacing as an earliest-grant cycle number.
  ent_t        mq[$];
  bit          m_age_p;
  ent_t        m_age;
  bit          m_valid;
  ent_t        m_out;
  bit          m_src;
  int          m_free_at;
  int          m_starve;
  int          m_drops;
  int          m_cyc;
  bit          m_have_last;
  logic [31:0] m_last_ip;
  int          m_last_cyc;

  typedef struct {
    logic [31:0] ip;
    bit          src;
  } emit_t;
  emit_t got[$];

  function automatic logic [23:0] np_of(input logic [31:0] ip);
    return ip[23:0] ^ 24'hA5A5A5;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_step();
    bit   ready_now;
    bit   sup;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_age_p = 0; m_age = '0; m_valid = 0; m_out = '0; m_src = 0;
      m_free_at = 0; m_starve = 0; m_drops = 0; m_cyc = 0;
      m_have_last = 0; m_last_ip = '0; m_last_cyc = 0;
      return;
    end
    ready_now = mq.size() < 4;
    if (m_valid) begin
      if (arp_tx_ready) begin
        m_valid   = 0;
        m_free_at = m_cyc + int'(GAP) + 1;
      end
    end else if (m_cyc >= m_free_at) begin
      if (m_age_p && (mq.size() == 0 || m_starve == int'(STARVE))) begin
        m_valid = 1; m_out = m_age; m_src = 1; m_starve = 0; m_age_p = 0;
      end else if (mq.size() > 0) begin
        e   = mq.pop_front();
        sup = 0;
`ifdef ARP_REQ_DEDUP_EN
        sup = m_have_last && (e.ip == m_last_ip) && (m_cyc - m_last_cyc <= int'(HOLD));
`endif
        if (!sup) begin
          m_valid = 1; m_out = e; m_src = 0;
          if (m_age_p) m_starve++;
          m_have_last = 1; m_last_ip = e.ip; m_last_cyc = m_cyc;
        end
      end
    end
    if (age_req_en) begin
      if (!m_age_p) begin
        m_age_p = 1;
        m_age   = '{np: age_netport, ip: age_ip};
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
    if (miss_valid && ready_now) mq.push_back('{np: miss_netport, ip: miss_ip});
    m_cyc++;
  endfunction

  task automatic model_compare();
    checkOutput("model_valid", arp_tx_valid, m_valid);
    if (m_valid) begin
      checkOutput("model_ip", arp_tx_ip, m_out.ip);
      checkOutput("model_netport", arp_tx_netport, m_out.np);
      checkOutput("model_src", arp_tx_src, m_src);
    end
    checkOutput("model_miss_ready", miss_ready, mq.size() < 4);
    checkOutput("model_drop_cnt", age_drop_cnt, m_drops);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    model_step();
    #1;
    model_compare();
  endtask

  task automatic driveIdle();
    miss_valid = 0; miss_ip = '0; miss_netport = '0;
    age_req_en = 0; age_ip = '0; age_netport = '0;
  endtask

  task automatic doReset();
    driveIdle();
    arp_tx_ready = 0;
    rst = 1;
    applyStimulus();
    applyStimulus();
    rst = 0;
  endtask

  // Hold ready high and record handshakes until n are seen or the budget runs out.
  task automatic collect(input int n, input int budget);
    got.delete();
    arp_tx_ready = 1;
    for (int k = 0; k < budget && got.size() < n; k++) begin
      if (arp_tx_valid && arp_tx_ready) got.push_back('{ip: arp_tx_ip, src: arp_tx_src});
      applyStimulus();
    end
    checkOutput("collect_count", got.size(), n);
  endtask

  task automatic pushMiss(input logic [31:0] ip);
    miss_valid = 1; miss_ip = ip; miss_netport = np_of(ip);
  endtask

  task automatic pulseAge(input logic [31:0] ip);
    age_req_en = 1; age_ip = ip; age_netport = np_of(ip);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[16];
    int   hs;
    int   pushed;
    bit   accepted;
    logic [31:0] rnd_last;

    tbl[0]  = '{1, 32'h0A000001, 0, 0,            1, 0, 0, 0,            0};
    tbl[1]  = '{1, 32'h0A000002, 0, 0,            1, 1, 0, 32'h0A000001, 0};
    tbl[2]  = '{0, 0,            0, 0,            1, 0, 0, 0,            0};
    tbl[3]  = '{0, 0,            0, 0,            1, 0, 0, 0,            0};
    tbl[4]  = '{0, 0,            0, 0,            1, 0, 0, 0,            0};
    tbl[5]  = '{0, 0,            0, 0,            1, 0, 0, 0,            0};
    tbl[6]  = '{0, 0,            0, 0,            1, 0, 0, 0,            0};
    tbl[7]  = '{0, 0,            0, 0,            1, 1, 0, 32'h0A000002, 0};
    tbl[8]  = '{0, 0,            1, 32'h0B0000C0, 1, 0, 0, 0,            0};
    tbl[9]  = '{0, 0,            1, 32'h0B0000D0, 1, 0, 0, 0,            1};
    tbl[10] = '{0, 0,            0, 0,            1, 0, 0, 0,            1};
    tbl[11] = '{0, 0,            0, 0,            1, 0, 0, 0,            1};
    tbl[12] = '{0, 0,            0, 0,            1, 0, 0, 0,            1};
    tbl[13] = '{0, 0,            0, 0,            0, 1, 1, 32'h0B0000C0, 1};
    tbl[14] = '{0, 0,            0, 0,            0, 1, 1, 32'h0B0000C0, 1};
    tbl[15] = '{0, 0,            0, 0,            1, 0, 0, 0,            1};

    driveIdle();
    arp_tx_ready = 0;
    rst = 1;
    doReset();
    checkOutput("reset_valid", arp_tx_valid, 0);
    checkOutput("reset_netport", arp_tx_netport, 0);
    checkOutput("reset_ip", arp_tx_ip, 0);
    checkOutput("reset_src", arp_tx_src, 0);
    checkOutput("reset_miss_ready", miss_ready, 1);
    checkOutput("reset_drop_cnt", age_drop_cnt, 0);

    // Latency, gap spacing and an age drop during the gap.
    for (int i = 0; i < 16; i++) begin
      miss_valid = tbl[i].mv; miss_ip = tbl[i].mip; miss_netport = np_of(tbl[i].mip);
      age_req_en = tbl[i].age; age_ip = tbl[i].aip; age_netport = np_of(tbl[i].aip);
      arp_tx_ready = tbl[i].rdy;
      applyStimulus();
      checkOutput($sformatf("tbl_valid[%0d]", i), arp_tx_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        checkOutput($sformatf("tbl_ip[%0d]", i), arp_tx_ip, tbl[i].eip);
        checkOutput($sformatf("tbl_netport[%0d]", i), arp_tx_netport, np_of(tbl[i].eip));
        checkOutput($sformatf("tbl_src[%0d]", i), arp_tx_src, tbl[i].esrc);
      end
      checkOutput($sformatf("tbl_miss_ready[%0d]", i), miss_ready, 1);
      checkOutput($sformatf("tbl_drop[%0d]", i), age_drop_cnt, tbl[i].edrop);
    end
    driveIdle();

    $display("[TB] back-pressure");
    doReset();
    pushMiss(32'h0A0000EE);
    applyStimulus();
    driveIdle();
    for (int k = 0; k < 10 && !arp_tx_valid; k++) applyStimulus();
    checkOutput("bp_valid_seen", arp_tx_valid, 1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus();
      checkOutput("bp_valid_stable", arp_tx_valid, 1);
      checkOutput("bp_ip_stable", arp_tx_ip, 32'h0A0000EE);
      checkOutput("bp_netport_stable", arp_tx_netport, np_of(32'h0A0000EE));
      checkOutput("bp_src_stable", arp_tx_src, 0);
    end
    arp_tx_ready = 1;
    hs = 0;
    for (int k = 0; k < 12; k++) begin
      if (arp_tx_valid && arp_tx_ready) hs++;
      applyStimulus();
    end
    checkOutput("bp_handshakes", hs, 1);

    $display("[TB] fifo full");
    doReset();
    pulseAge(32'h0C000001);
    applyStimulus();
    driveIdle();
    applyStimulus();
    checkOutput("full_age_busy", arp_tx_valid, 1);
    for (int w = 1; w <= 4; w++) begin
      checkOutput("full_ready_before_write", miss_ready, 1);
      pushMiss(32'h0D000000 + w);
      applyStimulus();
    end
    checkOutput("full_ready_after_4", miss_ready, 0);
    pushMiss(32'h0D000005);
    for (int k = 0; k < 5; k++) applyStimulus();
    checkOutput("full_ready_held_low", miss_ready, 0);
    arp_tx_ready = 1;
    accepted = 0;
    for (int k = 0; k < 40 && !accepted; k++) begin
      if (miss_ready) accepted = 1;
      applyStimulus();
    end
    checkOutput("full_fifth_accepted", accepted, 1);
    driveIdle();
    collect(4, 100);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checkOutput($sformatf("full_order_ip[%0d]", i), got[i].ip, 32'h0D000002 + i);
      checkOutput($sformatf("full_order_src[%0d]", i), got[i].src, 0);
    end

    $display("[TB] starvation");
    doReset();
    arp_tx_ready = 1;
    got.delete();
    pushed = 0;
    for (int k = 0; k < 200 && got.size() < 9; k++) begin
      if (pushed < 8) pushMiss(32'h0E000000 + pushed);
      else miss_valid = 0;
      if (k == 0) pulseAge(32'h0F0000AA);
      else age_req_en = 0;
      if (miss_valid && miss_ready) pushed++;
      if (arp_tx_valid && arp_tx_ready) got.push_back('{ip: arp_tx_ip, src: arp_tx_src});
      applyStimulus();
    end
    driveIdle();
    checkOutput("starve_count", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      checkOutput($sformatf("starve_src[%0d]", i), got[i].src, (i == 4));
      checkOutput($sformatf("starve_ip[%0d]", i), got[i].ip,
                  (i == 4) ? 32'h0F0000AA : 32'h0E000000 + ((i < 4) ? i : i - 1));
    end

    $display("[TB] age drop");
    doReset();
    pulseAge(32'h0C0000A1);
    applyStimulus();
    pulseAge(32'h0C0000A2);
    applyStimulus();
    driveIdle();
    applyStimulus();
    applyStimulus();
    pulseAge(32'h0C0000A3);
    applyStimulus();
    driveIdle();
    checkOutput("drop_count", age_drop_cnt, 1);
    collect(2, 40);
    if (got.size() == 2) begin
      checkOutput("drop_first_ip", got[0].ip, 32'h0C0000A1);
      checkOutput("drop_held_ip", got[1].ip, 32'h0C0000A2);
      checkOutput("drop_held_src", got[1].src, 1);
    end

    $display("[TB] reset during issue");
    doReset();
    pushMiss(32'h01010101);
    pulseAge(32'h02020202);
    applyStimulus();
    pushMiss(32'h01010102);
    age_req_en = 0;
    applyStimulus();
    pushMiss(32'h01010103);
    applyStimulus();
    driveIdle();
    checkOutput("rst_mid_valid_before", arp_tx_valid, 1);
    rst = 1;
    applyStimulus();
    rst = 0;
    checkOutput("rst_mid_valid_after", arp_tx_valid, 0);
    arp_tx_ready = 1;
    hs = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus();
      if (arp_tx_valid) hs++;
    end
    checkOutput("rst_mid_no_leftovers", hs, 0);
    checkOutput("rst_mid_miss_ready", miss_ready, 1);

    $display("[TB] repeated miss IP");
    doReset();
    arp_tx_ready = 1;
    hs = 0;
    for (int k = 0; k < 160; k++) begin
      if (k == 0 || k == 100) pushMiss(32'hC0A80001);
      else miss_valid = 0;
      if (arp_tx_valid && arp_tx_ready) hs++;
      applyStimulus();
    end
`ifdef ARP_REQ_DEDUP_EN
    checkOutput("dedup_emissions", hs, 1);
`else
    checkOutput("dedup_emissions", hs, 2);
`endif

    $display("[TB] random traffic");
    doReset();
    rnd_last = 32'h0A0A0A0A;
    for (int k = 0; k < 3000; k++) begin
      miss_valid = ($urandom % 3) == 0;
      miss_ip    = (($urandom % 4) == 0) ? rnd_last : $urandom;
      rnd_last   = miss_ip;
      miss_netport = 24'($urandom);
      age_req_en = ($urandom % 8) == 0;
      age_ip     = $urandom;
      age_netport = 24'($urandom);
      if (!(arp_tx_valid && arp_tx_ready)) arp_tx_ready = ($urandom % 4) != 0;
      else arp_tx_ready = ($urandom % 4) != 0;
      rst = ($urandom % 600) == 0;
      applyStimulus();
    end
    rst = 0;
    driveIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
